// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered 4-bit ALU among NUM_REQ requesters.
// One operation in flight: grant (IDLE) -> EXEC -> CAPT -> RESP -> IDLE.
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [4*NUM_REQ-1:0]   req_a,
  input  logic [4*NUM_REQ-1:0]   req_b,
  input  logic [3*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [3:0]             rsp_result,
  output logic                   rsp_carry,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_op,
  input  logic [3:0]             alu_result,
  input  logic                   alu_carry,
  output logic                   busy
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      last_grant, owner, grant_idx;
  logic               grant_found;
  logic               accept;
  logic [NUM_REQ-1:0] rsp_ready_sh;

  // Scan starts one past the previous winner and wraps, giving rotating priority.
  always_comb begin : arb
    int unsigned        cand;
    logic [NUM_REQ-1:0] valid_sh;
    cand        = 0;
    valid_sh    = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      valid_sh = req_valid >> cand;
      if (!grant_found && valid_sh[0]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  assign accept       = (state == IDLE) && grant_found;
  assign req_ready    = (accept && !rst) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign rsp_valid    = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
  assign rsp_ready_sh = rsp_ready >> owner;
  assign busy         = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant_found) state_nxt = EXEC;
      EXEC: state_nxt = CAPT;
      CAPT: state_nxt = RESP;
      RESP: if (rsp_ready_sh[0]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      owner      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a      <= 4'(req_a  >> (32'(grant_idx) * 4));
        alu_b      <= 4'(req_b  >> (32'(grant_idx) * 4));
        alu_op     <= 3'(req_op >> (32'(grant_idx) * 3));
        owner      <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == CAPT) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (NUM_REQ=2) with a behavioural registered ALU.
module tb_alu_arbiter;

  logic       clk, rst;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_a, req_b;
  logic [5:0] req_op;
  logic [3:0] rsp_result, alu_a, alu_b, alu_result;
  logic       rsp_carry, alu_carry, busy, alu_rst_n;
  logic [2:0] alu_op;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .busy(busy)
  );

  assign alu_rst_n = ~rst;

  // Registered 4-bit ALU stand-in.
  always @(posedge clk) begin
    if (!alu_rst_n) begin
      alu_result <= 4'd0;
      alu_carry  <= 1'b0;
    end else begin
      alu_carry <= 1'b0;
      case (alu_op)
        3'd0: {alu_carry, alu_result} <= {1'b0, alu_a} + {1'b0, alu_b};
        3'd1: {alu_carry, alu_result} <= {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        3'd2: alu_result <= alu_a & alu_b;
        3'd3: alu_result <= alu_a | alu_b;
        3'd4: alu_result <= alu_a ^ alu_b;
        3'd5: alu_result <= ~alu_a;
        3'd6: alu_result <= alu_a >> 1;
        default: alu_result <= alu_a << 1;
      endcase
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    req_a[idx*4 +: 4]  = a;
    req_b[idx*4 +: 4]  = b;
    req_op[idx*3 +: 3] = op;
  endtask

  task automatic do_op(input int idx, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic [3:0] er, input logic ec, input bit chk_res, input string tag);
    set_req(idx, a, b, op);
    req_valid = 2'(1 << idx);
    #1;
    check({tag, ".req_ready"}, req_ready, 1 << idx);
    check({tag, ".busy_idle"}, busy, 0);
    tick();
    req_valid = 2'b00;
    check({tag, ".alu_a"}, alu_a, a);
    check({tag, ".alu_b"}, alu_b, b);
    check({tag, ".alu_op"}, alu_op, op);
    check({tag, ".busy_exec"}, busy, 1);
    tick();
    tick();
    check({tag, ".rsp_valid"}, rsp_valid, 1 << idx);
    if (chk_res) check({tag, ".result"}, rsp_result, er);
    check({tag, ".carry"}, rsp_carry, ec);
    tick();
    check({tag, ".rsp_done"}, rsp_valid, 0);
    check({tag, ".busy_done"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; rsp_ready = 2'b11;
    req_a = '0; req_b = '0; req_op = '0;
    tick();
    tick();
    check("reset.busy", busy, 0);
    check("reset.rsp_valid", rsp_valid, 0);
    check("reset.req_ready", req_ready, 0);
    check("reset.alu_a", alu_a, 0);
    check("reset.result", rsp_result, 0);
    rst = 1'b0;

    // Basic add and carry/sub/shift cases
    do_op(0, 4'd5, 4'd3, 3'b000, 4'd8,  1'b0, 1'b1, "add0");
    do_op(1, 4'd9, 4'd9, 3'b000, 4'd2,  1'b1, 1'b1, "add_carry");
    do_op(1, 4'd3, 4'd5, 3'b001, 4'd14, 1'b0, 1'b1, "sub_borrow");
    do_op(0, 4'd6, 4'd3, 3'b110, 4'd0,  1'b0, 1'b0, "shr");

    // Round-robin with both continuously valid after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 4'd1, 4'd2, 3'b000);
    set_req(1, 4'd12, 4'd5, 3'b010);
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = i % 2;
      check("rr.grant", req_ready, 1 << g);
      tick();
      check("rr.ready_exec", req_ready, 0);
      check("rr.alu_a", alu_a, (g == 1) ? 12 : 1);
      tick();
      tick();
      check("rr.rsp_valid", rsp_valid, 1 << g);
      check("rr.result", rsp_result, (g == 1) ? 4 : 3);
      tick();
    end

    // Backpressure on req0 while req1 waits
    set_req(0, 4'd7, 4'd7, 3'b000);
    rsp_ready = 2'b10;
    req_valid = 2'b11;
    #1;
    check("bp.grant0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp.rsp_valid", rsp_valid, 2'b01);
      check("bp.result", rsp_result, 14);
      check("bp.carry", rsp_carry, 0);
      check("bp.req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 2'b11;
    #1;
    check("bp.rsp_valid_take", rsp_valid, 2'b01);
    check("bp.no_accept_on_take", req_ready, 0);
    tick();
    check("bp.grant1", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    check("bp.rsp1_valid", rsp_valid, 2'b10);
    check("bp.rsp1_result", rsp_result, 4);
    tick();

    // Reset during EXEC
    set_req(0, 4'd1, 4'd2, 3'b000);
    req_valid = 2'b11;
    #1;
    check("rst.grant0", req_ready, 2'b01);
    tick();
    rst = 1'b1;
    tick();
    check("rst.req_ready", req_ready, 0);
    check("rst.busy", busy, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.alu_a", alu_a, 0);
    check("rst.alu_b", alu_b, 0);
    check("rst.alu_op", alu_op, 0);
    check("rst.result", rsp_result, 0);
    check("rst.carry", rsp_carry, 0);
    rst = 1'b0;
    #1;
    check("rst.first_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    check("rst.rsp_valid_after", rsp_valid, 2'b01);
    check("rst.result_after", rsp_result, 3);
    tick();

    // Idle stability
    for (int i = 0; i < 10; i++) begin
      check("idle.busy", busy, 0);
      check("idle.req_ready", req_ready, 0);
      check("idle.rsp_valid", rsp_valid, 0);
      check("idle.alu_a", alu_a, 1);
      check("idle.alu_b", alu_b, 2);
      check("idle.alu_op", alu_op, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one registered 4-bit `alu` instance among `NUM_REQ` requesters. Each requester presents operands and an opcode with a valid/ready handshake. The block grants one request at a time and drives the ALU operand/opcode inputs. It then waits out the ALU's one-cycle register latency, captures result and carry, and returns them to the granted requester with a second valid/ready handshake. It sits between the requester ports and the `alu` instance at the same level of hierarchy. At top level the ALU's `rst_n` is driven by `~rst`.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  request valid, one bit per requester.
- `req_ready`  out  NUM_REQ  request accepted; at most one bit high.
- `req_a`  in  4*NUM_REQ  operand A; requester i uses bits [4i+3:4i].
- `req_b`  in  4*NUM_REQ  operand B; same packing as `req_a`.
- `req_op`  in  3*NUM_REQ  opcode; requester i uses bits [3i+2:3i]. Encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 shift right, 111 shift left.
- `rsp_valid`  out  NUM_REQ  response valid; one-hot to the owner of the operation.
- `rsp_ready`  in  NUM_REQ  response accepted; only the owner's bit is examined.
- `rsp_result`  out  4  captured ALU result.
- `rsp_carry`  out  1  captured ALU carry. The ALU drives this to 0 for op >= 010.
- `alu_a`, `alu_b`  out  4 each  registered operands to the ALU.
- `alu_op`  out  3  registered opcode to the ALU.
- `alu_result`  in  4  ALU registered result.
- `alu_carry`  in  1  ALU registered carry.
- `busy`  out  1  high in every state except IDLE.

## Operation
**FSM states:** IDLE, EXEC, CAPT, RESP. Reset state is IDLE.

**IDLE**
- Grant goes to the first requester with `req_valid=1`, scanning from `last_grant+1` modulo NUM_REQ.
- `req_ready` is combinational and is asserted only for the granted requester, only in IDLE.
- On the handshake (valid & ready):
  - the winner's a/b/op are loaded into `alu_a`/`alu_b`/`alu_op`;
  - `owner` and `last_grant` are set to the winner's index;
  - next state is EXEC.
- If no requester is valid, the block stays in IDLE and `req_ready` is all 0.

**EXEC**
- ALU inputs are stable and the ALU registers its result at the end of this cycle.
- Next state is CAPT unconditionally.

**CAPT**
- `alu_result` and `alu_carry` are latched into `rsp_result` and `rsp_carry`.
- Next state is RESP.

**RESP**
- `rsp_valid[owner]=1`.
- On `rsp_ready[owner]=1`, next state is IDLE and `rsp_valid` clears.
- `rsp_ready` bits of non-owners are ignored.

**Held values**
- `alu_a`/`alu_b`/`alu_op` hold their last values outside IDLE handshakes. The ALU keeps recomputing the same result, which is harmless.
- `rsp_result`/`rsp_carry` hold until the next CAPT.

**Requester rules**
- Requesters must hold a/b/op stable while `req_valid=1` without `req_ready`.
- A valid request is never dropped by the arbiter except on reset.
- The grant decision is made and consumed in the same cycle, so a requester deasserting valid before its grant simply loses its turn.

**Arithmetic**
- Widths are fixed at 4 bits; no sign handling in this block.
- Sub carry is the raw ALU carry-out of A + ~B + 1: 1 means no borrow.

**Reset**
- `rst` in any state clears the following at the next edge:
  - state = IDLE;
  - `last_grant` = NUM_REQ-1, so requester 0 has first priority after reset;
  - `owner` = 0;
  - `alu_a`/`alu_b`/`alu_op` = 0;
  - `rsp_result` = 0, `rsp_carry` = 0;
  - `rsp_valid` = 0, `busy` = 0.
- `req_ready` is 0 while `rst=1`.
- An in-flight operation is discarded with no response.

## Timing
- Handshake accepted in cycle T (IDLE).
- `alu_*` outputs valid in T+1 (EXEC).
- ALU output valid in T+2 (CAPT).
- `rsp_valid` high from T+3.
- Minimum request-to-request spacing is 4 cycles: response taken in T+3, next grant in T+4.
- No request is accepted in the cycle a response is consumed.
- Only one operation is in flight at a time; there is no pipelining.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 operations.
- Backpressure: `rsp_ready` low holds RESP indefinitely. `rsp_result`/`rsp_carry`/`rsp_valid` must stay stable and `req_ready` stays 0 throughout.

## Test plan
1. **Basic add:** NUM_REQ=2, req0 a=5 b=3 op=000, `rsp_ready` tied high.
   - `req_ready[0]` in T, `alu_a`=5/`alu_b`=3 in T+1.
   - `rsp_valid`=01, result=8, carry=0 in T+3.
2. **Carry and sub:** req1 a=9 b=9 op=000 gives result=2, carry=1. req1 a=3 b=5 op=001 gives result=14, carry=0. req0 a=6 b=3 op=110 gives carry=0.
3. **Round-robin:** both requesters valid continuously for 4 operations after reset.
   - Grant order 0,1,0,1, each grant 4 cycles apart.
   - Each `rsp_valid` is routed to the matching requester with the correct result.
4. **Backpressure:** req0 add 7+7, `rsp_ready[0]` held low for 5 cycles while `rsp_ready[1]`=1 and req1 valid.
   - `rsp_valid`=01 and result=14 stay stable.
   - `req_ready`=00 throughout; req1 is granted the cycle after `rsp_ready[0]` rises.
5. **Reset mid-op:** `rst` pulsed during EXEC with req0 in flight and req1 waiting.
   - Next cycle all outputs are 0 and state is IDLE; no response is issued.
   - With both valid after reset, req0 is granted first.
6. **Idle stability:** no `req_valid` for 10 cycles. `busy`=0, `req_ready`=0, `rsp_valid`=0, and `alu_*` unchanged.
